// File: rtl/quota_regulator.sv
// Per-core quota enforcement: stalls the core bus request channel between quota interrupt and period expiry.
// Optional build macro QUOTA_REGULATOR_STATS_EN enables the throttle_cycles_o counter (tied to 0 otherwise).
module quota_regulator #(
  parameter int PERIOD_WIDTH = 32,
  parameter int STAT_WIDTH   = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    enable_i,
  input  logic [PERIOD_WIDTH-1:0] period_i,
  input  logic                    intr_quota_i,
  output logic                    softrst_o,
  output logic                    throttle_o,
  input  logic                    req_i,
  output logic                    gnt_o,
  output logic                    req_o,
  input  logic                    gnt_i,
  output logic [STAT_WIDTH-1:0]   periods_throttled_o,
  output logic [STAT_WIDTH-1:0]   throttle_cycles_o
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REFILL,
    ST_GUARD,
    ST_RUN,
    ST_DRAIN,
    ST_THROTTLE
  } state_t;

  state_t                  state_reg, state_next;
  logic [PERIOD_WIDTH-1:0] cnt_reg, cnt_next;
  logic [PERIOD_WIDTH-1:0] eff_period;
  logic                    expiry;
  logic [STAT_WIDTH-1:0]   periods_throttled_reg;
  logic                    period_throttled;

  // Periods below 2 are clamped; >= also catches a period lowered under the running count.
  assign eff_period = (period_i < PERIOD_WIDTH'(2)) ? PERIOD_WIDTH'(2) : period_i;
  assign expiry     = (cnt_reg >= (eff_period - PERIOD_WIDTH'(1)));

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:   if (enable_i) state_next = ST_REFILL;
      ST_REFILL: state_next = ST_GUARD;
      ST_GUARD:  state_next = ST_RUN;
      ST_RUN: begin
        if (expiry)
          state_next = ST_REFILL;
        else if (intr_quota_i)
          state_next = (req_i && !gnt_i) ? ST_DRAIN : ST_THROTTLE;
      end
      ST_DRAIN: begin
        if (expiry)
          state_next = ST_REFILL;
        else if (!req_i || gnt_i)
          state_next = ST_THROTTLE;
      end
      ST_THROTTLE: if (expiry) state_next = ST_REFILL;
      default:     state_next = ST_IDLE;
    endcase
    if (!enable_i)
      state_next = ST_IDLE;
  end

  // Counter equals the number of cycles since the refill cycle.
  always_comb begin
    cnt_next = cnt_reg + PERIOD_WIDTH'(1);
    if (state_next == ST_IDLE || state_next == ST_REFILL)
      cnt_next = '0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  assign period_throttled = (state_reg == ST_THROTTLE) && (state_next == ST_REFILL);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)
      periods_throttled_reg <= '0;
    else if (period_throttled && (periods_throttled_reg != '1))
      periods_throttled_reg <= periods_throttled_reg + STAT_WIDTH'(1);
  end

`ifdef QUOTA_REGULATOR_STATS_EN
  logic [STAT_WIDTH-1:0] throttle_cycles_reg;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)
      throttle_cycles_reg <= '0;
    else if ((state_reg == ST_THROTTLE) && (throttle_cycles_reg != '1))
      throttle_cycles_reg <= throttle_cycles_reg + STAT_WIDTH'(1);
  end

  assign throttle_cycles_o = throttle_cycles_reg;
`else
  assign throttle_cycles_o = '0;
`endif

  // Gating depends only on registered state, so an in-flight request is never cut mid-handshake.
  assign throttle_o          = (state_reg == ST_THROTTLE);
  assign softrst_o           = (state_reg == ST_REFILL);
  assign req_o               = throttle_o ? 1'b0 : req_i;
  assign gnt_o               = throttle_o ? 1'b0 : gnt_i;
  assign periods_throttled_o = periods_throttled_reg;

endmodule
